// File: rtl/bcd_down_counter_if.sv
// Bus interface for the cascaded BCD down counter: control strobes and
// reload data flow from the master into the counter; count and status
// flags flow back out.
interface bcd_down_counter_if #(
  parameter int DIGITS = 4
);
  localparam int WID = 4 * DIGITS;

  logic           tick;
  logic           start;
  logic           stop;
  logic           oneshot;
  logic           wr_reload;
  logic [WID-1:0] reload_din;
  logic           force_load;
  logic [WID-1:0] count;
  logic           running;
  logic           underflow;
  logic           zero;

  modport master (
    output tick, start, stop, oneshot, wr_reload, reload_din, force_load,
    input  count, running, underflow, zero
  );

  modport slave (
    input  tick, start, stop, oneshot, wr_reload, reload_din, force_load,
    output count, running, underflow, zero
  );
endinterface

// File: rtl/bcd_down_counter.sv
// Multi-digit BCD down counter with reload register, one-shot and
// continuous modes, a one-cycle underflow pulse and a zero flag.
// Digit 0 sits in the low nibble; borrows ripple upward through the digits.
module bcd_down_counter #(
  parameter int DIGITS = 4,
  parameter int WID    = 4 * DIGITS
) (
  input  logic               clk,
  input  logic               rst_n,
  bcd_down_counter_if.slave  bus
);

  localparam logic [0:0] ST_STOP = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]     state_q, state_d;
  logic [WID-1:0] count_q, count_d;
  logic [WID-1:0] reload_q, reload_d;
  logic           underflow_q, underflow_d;
  logic           countEn;
  logic           underflowEvt;

  // Ripple a borrow from digit 0 upward. A zero digit wraps to 9 and passes
  // the borrow on; any other digit (including non-BCD A..F) just drops by one
  // in binary and absorbs the borrow, so invalid codes are never corrected.
  function automatic logic [WID-1:0] bcdDecrement(input logic [WID-1:0] value,
                                                  input logic           borrowIn);
    logic           borrow;
    logic [3:0]     digit;
    logic [WID-1:0] result;
    borrow = borrowIn;
    result = value;
    for (int i = 0; i < DIGITS; i++) begin
      digit = value[4*i +: 4];
      if (borrow) begin
        if (digit == 4'd0) begin
          result[4*i +: 4] = 4'd9;
          borrow           = 1'b1;
        end else begin
          result[4*i +: 4] = digit - 4'd1;
          borrow           = 1'b0;
        end
      end
    end
    return result;
  endfunction

  // Next-state decode: force_load beats underflow beats plain decrement,
  // stop beats start, and a tick is judged against the current state only.
  always_comb begin
    countEn      = bus.tick && (state_q == ST_RUN);
    underflowEvt = countEn && (count_q == '0);

    reload_d = bus.wr_reload ? bus.reload_din : reload_q;

    count_d = count_q;
    if (bus.force_load) begin
      count_d = bus.wr_reload ? bus.reload_din : reload_q;
    end else if (underflowEvt) begin
      count_d = reload_q;
    end else if (countEn) begin
      count_d = bcdDecrement(count_q, countEn);
    end

    underflow_d = underflowEvt && !bus.force_load;

    state_d = state_q;
    if (bus.stop) begin
      state_d = ST_STOP;
    end else if ((state_q == ST_STOP) && bus.start) begin
      state_d = ST_RUN;
    end else if (underflow_d && bus.oneshot) begin
      state_d = ST_STOP;
    end
  end

  // Register update with synchronous active-low reset overriding all inputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_STOP;
      count_q     <= '0;
      reload_q    <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      reload_q    <= reload_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.count     = count_q;
  assign bus.running   = (state_q == ST_RUN);
  assign bus.underflow = underflow_q;
  assign bus.zero      = (count_q == '0);

endmodule

// File: tb/tb_bcd_down_counter.sv
// Self-checking bench for bcd_down_counter (DIGITS=4): a table of one-cycle
// vectors plus hand-written multi-cycle sequences. Each applied vector pushes
// its expected outputs onto a queue that is popped once the edge has passed.
module tb_bcd_down_counter;

  localparam int DIGITS = 4;
  localparam int WID    = 4 * DIGITS;

  typedef struct {
    logic           rstN;
    logic           tick;
    logic           start;
    logic           stop;
    logic           oneshot;
    logic           wrReload;
    logic           forceLoad;
    logic [WID-1:0] din;
    logic [WID-1:0] expCount;
    logic           expRunning;
    logic           expUnderflow;
  } vec_t;

  typedef struct {
    int             tag;
    logic [WID-1:0] count;
    logic           running;
    logic           underflow;
    logic           zero;
  } exp_t;

  logic clk;
  logic rst_n;
  bcd_down_counter_if #(.DIGITS(DIGITS)) bus ();

  bcd_down_counter #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   compared   = 0;
  int   mismatched = 0;
  int   stepTag    = 0;
  exp_t scoreboard[$];
  vec_t vecs[$];

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mkVec(input logic rstN, input logic tick,
                                 input logic start, input logic stop,
                                 input logic oneshot, input logic wrReload,
                                 input logic forceLoad, input logic [WID-1:0] din,
                                 input logic [WID-1:0] expCount,
                                 input logic expRunning, input logic expUnderflow);
    vec_t v;
    v.rstN = rstN; v.tick = tick; v.start = start; v.stop = stop;
    v.oneshot = oneshot; v.wrReload = wrReload; v.forceLoad = forceLoad;
    v.din = din; v.expCount = expCount; v.expRunning = expRunning;
    v.expUnderflow = expUnderflow;
    return v;
  endfunction

  function automatic logic [WID-1:0] toBcd(input int value);
    logic [WID-1:0] r;
    int             v;
    r = '0;
    v = value;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic checkField(input string name, input int tag,
                            input logic [WID-1:0] actual,
                            input logic [WID-1:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL step %0d %s: got %h, required %h", tag, name, actual, expected);
    end
  endtask

  // Pop the oldest expectation and compare it with what the DUT shows now.
  task automatic checkOutput();
    exp_t e;
    compared++;
    if (scoreboard.size() == 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard: got empty queue, required an entry");
      return;
    end
    compared--;
    e = scoreboard.pop_front();
    checkField("count",     e.tag, bus.count,               e.count);
    checkField("running",   e.tag, {{(WID-1){1'b0}}, bus.running},   {{(WID-1){1'b0}}, e.running});
    checkField("underflow", e.tag, {{(WID-1){1'b0}}, bus.underflow}, {{(WID-1){1'b0}}, e.underflow});
    checkField("zero",      e.tag, {{(WID-1){1'b0}}, bus.zero},      {{(WID-1){1'b0}}, e.zero});
  endtask

  // Drive one vector for one clock, record its expectation, check after the edge.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    @(negedge clk);
    rst_n          = v.rstN;
    bus.tick       = v.tick;
    bus.start      = v.start;
    bus.stop       = v.stop;
    bus.oneshot    = v.oneshot;
    bus.wr_reload  = v.wrReload;
    bus.force_load = v.forceLoad;
    bus.reload_din = v.din;
    e.tag       = stepTag;
    e.count     = v.expCount;
    e.running   = v.expRunning;
    e.underflow = v.expUnderflow;
    e.zero      = (v.expCount == '0);
    scoreboard.push_back(e);
    stepTag++;
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no completion, required finish before 200000");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n = 1'b0;
    bus.tick = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; bus.oneshot = 1'b0;
    bus.wr_reload = 1'b0; bus.force_load = 1'b0; bus.reload_din = '0;

    //          rstN tick strt stop os  wr  fl  din       expCount  run uf
    // Reset with all other inputs active, then reload register reads back 0.
    vecs.push_back(mkVec(0, 1, 1, 0, 1, 1, 1, 16'h1234, 16'h0000, 0, 0));
    vecs.push_back(mkVec(1, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0));
    // One-shot: reload 2, three ticks, then ticks in STOP are ignored.
    vecs.push_back(mkVec(1, 0, 0, 0, 1, 1, 1, 16'h0002, 16'h0002, 0, 0));
    vecs.push_back(mkVec(1, 0, 1, 0, 1, 0, 0, 16'h0000, 16'h0002, 1, 0));
    vecs.push_back(mkVec(1, 1, 0, 0, 1, 0, 0, 16'h0000, 16'h0001, 1, 0));
    vecs.push_back(mkVec(1, 1, 0, 0, 1, 0, 0, 16'h0000, 16'h0000, 1, 0));
    vecs.push_back(mkVec(1, 1, 0, 0, 1, 0, 0, 16'h0000, 16'h0002, 0, 1));
    vecs.push_back(mkVec(1, 1, 0, 0, 1, 0, 0, 16'h0000, 16'h0002, 0, 0));
    vecs.push_back(mkVec(1, 1, 0, 0, 0, 0, 0, 16'h0000, 16'h0002, 0, 0));
    // Priority: force_load with write-through beats an underflow tick.
    vecs.push_back(mkVec(1, 0, 0, 0, 0, 1, 1, 16'h0000, 16'h0000, 0, 0));
    vecs.push_back(mkVec(1, 0, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 0));
    vecs.push_back(mkVec(1, 1, 0, 0, 0, 1, 1, 16'h0050, 16'h0050, 1, 0));
    vecs.push_back(mkVec(1, 1, 0, 0, 0, 0, 0, 16'h0000, 16'h0049, 1, 0));
    // start+stop together: stop wins from RUN and from STOP.
    vecs.push_back(mkVec(1, 0, 1, 1, 0, 0, 0, 16'h0000, 16'h0049, 0, 0));
    vecs.push_back(mkVec(1, 0, 1, 1, 0, 0, 0, 16'h0000, 16'h0049, 0, 0));
    // stop with a tick still decrements; tick in STOP is ignored.
    vecs.push_back(mkVec(1, 0, 1, 0, 0, 0, 0, 16'h0000, 16'h0049, 1, 0));
    vecs.push_back(mkVec(1, 1, 0, 1, 0, 0, 0, 16'h0000, 16'h0048, 0, 0));
    vecs.push_back(mkVec(1, 1, 0, 0, 0, 0, 0, 16'h0000, 16'h0048, 0, 0));
    // wr_reload alone leaves count alone; a later force_load picks it up.
    vecs.push_back(mkVec(1, 0, 0, 0, 0, 1, 0, 16'h0007, 16'h0048, 0, 0));
    vecs.push_back(mkVec(1, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0007, 0, 0));
    // Invalid BCD digits decrement in binary without correction.
    vecs.push_back(mkVec(1, 0, 0, 0, 0, 1, 1, 16'h000C, 16'h000C, 0, 0));
    vecs.push_back(mkVec(1, 0, 1, 0, 0, 0, 0, 16'h0000, 16'h000C, 1, 0));
    vecs.push_back(mkVec(1, 1, 0, 0, 0, 0, 0, 16'h0000, 16'h000B, 1, 0));
    vecs.push_back(mkVec(1, 1, 0, 0, 0, 0, 0, 16'h0000, 16'h000A, 1, 0));
    vecs.push_back(mkVec(1, 1, 0, 0, 0, 0, 0, 16'h0000, 16'h0009, 1, 0));
    vecs.push_back(mkVec(1, 0, 0, 0, 0, 1, 1, 16'h00A0, 16'h00A0, 1, 0));
    vecs.push_back(mkVec(1, 1, 0, 0, 0, 0, 0, 16'h0000, 16'h0099, 1, 0));
    // Reset in the middle of a run, coincident with a tick.
    vecs.push_back(mkVec(1, 0, 0, 0, 0, 1, 1, 16'h0123, 16'h0123, 1, 0));
    vecs.push_back(mkVec(0, 1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0));
    vecs.push_back(mkVec(1, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0));

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Digit cascade: 1000 -> 0999, then count down to 0000, then underflow.
    applyStimulus(mkVec(1, 0, 0, 0, 0, 1, 1, 16'h1000, 16'h1000, 0, 0));
    applyStimulus(mkVec(1, 0, 1, 0, 0, 0, 0, 16'h0000, 16'h1000, 1, 0));
    applyStimulus(mkVec(1, 1, 0, 0, 0, 0, 0, 16'h0000, 16'h0999, 1, 0));
    for (int k = 998; k >= 0; k--) begin
      applyStimulus(mkVec(1, 1, 0, 0, 0, 0, 0, 16'h0000, toBcd(k), 1, 0));
    end
    applyStimulus(mkVec(1, 1, 0, 0, 0, 0, 0, 16'h0000, 16'h1000, 1, 1));
    applyStimulus(mkVec(1, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h1000, 1, 0));

    // Continuous mode with reload 0: every tick underflows, state stays RUN.
    applyStimulus(mkVec(1, 0, 0, 0, 0, 1, 1, 16'h0000, 16'h0000, 1, 0));
    applyStimulus(mkVec(1, 1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 1));
    applyStimulus(mkVec(1, 1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 1));
    applyStimulus(mkVec(1, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 0));

    compared++;
    if (scoreboard.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard drain: got %0d entries left, required 0", scoreboard.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
